// File: rtl/error_capture_sequencer.sv
// rtl/error_capture_sequencer.sv - Captures one frame of per-BPM X/Y errors and paces them out to the converter
module error_capture_sequencer #(
  parameter int INDEX_WIDTH   = 9,
  parameter int MAX_COUNT     = 32,
  parameter int WRITE_SPACING = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   configStrobe,
  input  logic                   controlStrobe,
  input  logic [31:0]            csrData,
  output logic [31:0]            status,
  input  logic                   frameStart,
  input  logic                   frameEnd,
  input  logic                   sampleValid,
  input  logic [INDEX_WIDTH-1:0] sampleIndex,
  input  logic [31:0]            sampleX,
  input  logic [31:0]            sampleY,
  output logic                   errorStrobe,
  output logic [31:0]            errorData
);

  localparam int CNT_W  = $clog2(MAX_COUNT + 1);
  localparam int SLOT_W = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam int PTR_W  = CNT_W + 1;
  localparam int OFS_W  = INDEX_WIDTH + 1;
  localparam int PACE_W = $clog2(WRITE_SPACING);
  localparam logic [31:0] MISSING_WORD = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                 state;
  state_t                 next_state;
  logic [INDEX_WIDTH-1:0] first_index;
  logic [CNT_W-1:0]       win_count;
  logic [MAX_COUNT-1:0]   slot_valid;
  logic [31:0]            x_buf [MAX_COUNT];
  logic [31:0]            y_buf [MAX_COUNT];
  logic [PTR_W-1:0]       rd_ptr;
  logic [PACE_W-1:0]      pace;
  logic [31:0]            rd_word;
  logic                   rd_present;
  logic [7:0]             words_emitted;
  logic [15:0]            frame_count;
  logic                   missing_flag;
  logic                   overrun_flag;
  logic                   do_read;
  logic                   do_strobe;

  logic ctrl_arm, ctrl_abort, ctrl_clear;
  assign ctrl_arm   = controlStrobe & csrData[0];
  assign ctrl_abort = controlStrobe & csrData[1];
  assign ctrl_clear = controlStrobe & csrData[2];

  // Bits of the CSR word that carry no meaning for this block
  logic unused_csr_bits;
  assign unused_csr_bits = ^{csrData[31:24], csrData[15:INDEX_WIDTH]};

  // Clamp the requested window length into 1..MAX_COUNT
  logic [7:0]       cfg_raw;
  logic [CNT_W-1:0] cfg_count;
  assign cfg_raw = csrData[23:16];
  always_comb begin
    cfg_count = CNT_W'(MAX_COUNT);
    if (cfg_raw == 8'd0) begin
      cfg_count = CNT_W'(1);
    end else if ({24'd0, cfg_raw} <= 32'(MAX_COUNT)) begin
      cfg_count = CNT_W'(cfg_raw);
    end
  end

  // Window test is done on the unwrapped difference so first+count never wraps the index space
  logic [OFS_W-1:0]  offset;
  logic              in_window;
  logic              capture_wr;
  logic [SLOT_W-1:0] slot_wr;
  assign offset     = {1'b0, sampleIndex} - {1'b0, first_index};
  assign in_window  = ~offset[OFS_W-1] && (offset < OFS_W'(win_count));
  assign capture_wr = (state == S_CAPTURE) && sampleValid && in_window;
  assign slot_wr    = offset[SLOT_W-1:0];

  logic [PTR_W-1:0]  last_ptr;
  logic [SLOT_W-1:0] rd_slot;
  assign last_ptr = {win_count, 1'b0} - PTR_W'(1);
  assign rd_slot  = rd_ptr[SLOT_W:1];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and drain phase decode; abort overrides everything and kills any pending strobe
  always_comb begin
    next_state = state;
    do_read    = 1'b0;
    do_strobe  = 1'b0;
    case (state)
      S_IDLE:    if (ctrl_arm) next_state = S_ARMED;
      S_ARMED:   if (frameStart) next_state = S_CAPTURE;
      S_CAPTURE: if (frameEnd || frameStart) next_state = S_DRAIN;
      S_DRAIN: begin
        do_read   = (pace == '0);
        do_strobe = (pace == PACE_W'(1));
        if (do_strobe && (rd_ptr == last_ptr)) next_state = S_DONE;
      end
      S_DONE:    next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
    if (ctrl_abort) begin
      next_state = S_IDLE;
      do_read    = 1'b0;
      do_strobe  = 1'b0;
    end
  end

  // Sample storage; contents are only trusted where slot_valid is set
  always_ff @(posedge clk) begin
    if (capture_wr) begin
      x_buf[slot_wr] <= sampleX;
      y_buf[slot_wr] <= sampleY;
    end
  end

  // Config, flags, slot-valid tracking, drain pacing and output words
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_index   <= '0;
      win_count     <= '0;
      slot_valid    <= '0;
      rd_ptr        <= '0;
      pace          <= '0;
      rd_word       <= '0;
      rd_present    <= 1'b0;
      words_emitted <= '0;
      frame_count   <= '0;
      missing_flag  <= 1'b0;
      overrun_flag  <= 1'b0;
      errorStrobe   <= 1'b0;
      errorData     <= '0;
    end else begin
      errorStrobe <= 1'b0;

      if (configStrobe && (state == S_IDLE)) begin
        first_index <= csrData[INDEX_WIDTH-1:0];
        win_count   <= cfg_count;
      end

      if (ctrl_clear) begin
        missing_flag <= 1'b0;
        overrun_flag <= 1'b0;
      end
      if ((state == S_CAPTURE) && frameStart) overrun_flag <= 1'b1;

      if ((state == S_ARMED) && frameStart) begin
        slot_valid <= '0;
      end else if (capture_wr) begin
        slot_valid[slot_wr] <= 1'b1;
      end

      if (state != S_DRAIN) begin
        pace   <= '0;
        rd_ptr <= '0;
      end else if (pace == PACE_W'(WRITE_SPACING - 1)) begin
        pace <= '0;
      end else begin
        pace <= pace + PACE_W'(1);
      end

      if ((state == S_CAPTURE) && (next_state == S_DRAIN)) words_emitted <= '0;

      if (do_read) begin
        rd_word    <= rd_ptr[0] ? y_buf[rd_slot] : x_buf[rd_slot];
        rd_present <= slot_valid[rd_slot];
      end

      if (do_strobe) begin
        errorStrobe   <= 1'b1;
        errorData     <= rd_present ? rd_word : MISSING_WORD;
        rd_ptr        <= rd_ptr + PTR_W'(1);
        words_emitted <= words_emitted + 8'd1;
        if (!rd_present) missing_flag <= 1'b1;
      end

      if (state == S_DONE) frame_count <= frame_count + 16'd1;
    end
  end

  assign status = {frame_count, words_emitted, 4'b0000, overrun_flag, missing_flag,
                   (state == S_ARMED), ((state == S_CAPTURE) || (state == S_DRAIN))};

endmodule
